// File: rtl/paged_mem_ctrl_if.sv
// CPU-side bus of the paged memory controller: access strobe, decoded selects and paging state.
interface paged_mem_ctrl_if #(
  parameter int ROM_BANKS = 16
);
  localparam int BW = $clog2(ROM_BANKS);

  logic          model;
  logic          cpu_req;
  logic [15:0]   cpu_a;
  logic          cpu_we;
  logic [7:0]    cpu_di;
  logic          cpu_ready;
  logic          ram_cs;
  logic          rom_cs;
  logic          ddr_cs;
  logic          mos_cs;
  logic [15:0]   io_cs;
  logic          fredjim_cs;
  logic [BW-1:0] rom_bank;
  logic          shadow;
  logic [7:0]    acccon_q;
  logic          slow_busy;

  modport master (
    output model, cpu_req, cpu_a, cpu_we, cpu_di,
    input  cpu_ready, ram_cs, rom_cs, ddr_cs, mos_cs, io_cs, fredjim_cs,
           rom_bank, shadow, acccon_q, slow_busy
  );

  modport slave (
    input  model, cpu_req, cpu_a, cpu_we, cpu_di,
    output cpu_ready, ram_cs, rom_cs, ddr_cs, mos_cs, io_cs, fredjim_cs,
           rom_bank, shadow, acccon_q, slow_busy
  );
endinterface

// File: rtl/paged_mem_ctrl.sv
// Registered BBC/Master address decode with ROMSEL/ACCCON paging and 1 MHz bus stretching.
//   state | meaning
//   IDLE  | waiting for cpu_req
//   FAST  | selects valid, full-speed access
//   SLOW  | selects valid, stretched to a 1 MHz phase edge
//   DONE  | cpu_ready pulse, register writes commit
module paged_mem_ctrl #(
  parameter int ROM_BANKS = 16,
  parameter int EXT_BANKS = 8,
  parameter int DIV       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  paged_mem_ctrl_if.slave   bus
);
  localparam int BW     = $clog2(ROM_BANKS);
  localparam int CW     = $clog2(DIV);
  localparam int TW     = $clog2(DIV / 2 + 1);
  localparam int LAST_I = DIV - 1;
  localparam int HALF_I = DIV / 2;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];
  localparam logic [TW-1:0] HALF = HALF_I[TW-1:0];
  localparam logic [BW:0]   EXT  = EXT_BANKS[BW:0];

  typedef enum logic [1:0] {IDLE, FAST, SLOW, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0] phase_cnt;
  logic          phase_edge;
  logic [TW-1:0] slow_tmr;
  logic          accept;

  logic [7:0]    off;
  logic          sheila, dec_fj, dec_slow, dec_romsel, dec_acccon;
  logic [20:0]   dec_sel, sel_q;

  logic          we_q, model_q, romsel_q, acccon_hit_q;
  logic [7:0]    di_q, acccon_r;
  logic [BW-1:0] rom_bank_q;
  logic          unused_addr;

  assign unused_addr = ^bus.cpu_a[1:0];
  assign accept      = (state == IDLE) && bus.cpu_req;
  assign phase_edge  = (phase_cnt == LAST);

  // Decode runs on the live request; only the results are latched.
  always_comb begin
    off        = bus.cpu_a[7:0];
    sheila     = (bus.cpu_a[15:8] == 8'hFE);
    dec_fj     = (bus.cpu_a[15:9] == 7'b1111110);
    dec_slow   = dec_fj ||
                 (sheila && ((off[7:5] == 3'b000) || (off[7:6] == 2'b01) ||
                             (!bus.model && off[7:5] == 3'b110)));
    dec_romsel = sheila && (off[7:4] == 4'h3) && (!bus.model || off[3:2] == 2'b00);
    dec_acccon = sheila && bus.model && (off[7:2] == 6'b001101);
    dec_sel    = '0;
    dec_sel[20] = !bus.cpu_a[15];
    dec_sel[19] = (bus.cpu_a[15:14] == 2'b10) && ({1'b0, rom_bank_q} <  EXT);
    dec_sel[18] = (bus.cpu_a[15:14] == 2'b10) && ({1'b0, rom_bank_q} >= EXT);
    dec_sel[17] = (bus.cpu_a[15:14] == 2'b11) && !dec_fj && !sheila;
    dec_sel[16] = dec_fj;
    if (sheila) dec_sel[15:0] = 16'h0001 << off[7:4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.cpu_req) state_nx = dec_slow ? SLOW : FAST;
      FAST:    state_nx = DONE;
      SLOW:    if (phase_edge && slow_tmr == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_ready = (state == DONE);
    bus.slow_busy = (state == SLOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
      slow_tmr  <= '0;
    end else begin
      phase_cnt <= phase_edge ? '0 : phase_cnt + CW'(1);
      if (accept)
        slow_tmr <= HALF;
      else if (state == SLOW && slow_tmr != '0)
        slow_tmr <= slow_tmr - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q        <= '0;
      we_q         <= 1'b0;
      di_q         <= '0;
      model_q      <= 1'b0;
      romsel_q     <= 1'b0;
      acccon_hit_q <= 1'b0;
      rom_bank_q   <= '0;
      acccon_r     <= '0;
    end else begin
      if (accept) begin
        sel_q        <= dec_sel;
        we_q         <= bus.cpu_we;
        di_q         <= bus.cpu_di;
        model_q      <= bus.model;
        romsel_q     <= dec_romsel;
        acccon_hit_q <= dec_acccon;
      end else if (state == DONE) begin
        sel_q <= '0;
        if (we_q && romsel_q)     rom_bank_q <= di_q[BW-1:0];
        if (we_q && acccon_hit_q) acccon_r   <= di_q;
      end
    end
  end

  assign bus.ram_cs     = sel_q[20];
  assign bus.rom_cs     = sel_q[19];
  assign bus.ddr_cs     = sel_q[18];
  assign bus.mos_cs     = sel_q[17];
  assign bus.fredjim_cs = sel_q[16];
  assign bus.io_cs      = sel_q[15:0];
  assign bus.rom_bank   = rom_bank_q;
  assign bus.acccon_q   = model_q ? acccon_r : 8'h00;
  assign bus.shadow     = model_q & acccon_r[2];
endmodule

// File: tb/tb_paged_mem_ctrl.sv
// Directed vector bench for paged_mem_ctrl: decode table plus phase, reset and overlap sequences.
module tb_paged_mem_ctrl;
  localparam int DIV = 32;
  localparam int LIM = 4 * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  paged_mem_ctrl_if #(.ROM_BANKS(16)) bus ();
  paged_mem_ctrl #(.ROM_BANKS(16), .EXT_BANKS(8), .DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tb_cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        model;
    logic [15:0] a;
    logic        we;
    logic [7:0]  di;
    logic [20:0] sel;
    logic        slow;
    logic [3:0]  bank;
    logic [7:0]  acc;
  } vec_t;
  vec_t vecs[16];

  localparam logic [20:0] S_RAM = 21'h100000, S_ROM = 21'h080000, S_DDR = 21'h040000,
                          S_MOS = 21'h020000, S_FJ  = 21'h010000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] sels();
    return {bus.ram_cs, bus.rom_cs, bus.ddr_cs, bus.mos_cs, bus.fredjim_cs, bus.io_cs};
  endfunction

  task automatic drive(input logic m, input logic [15:0] a, input logic we, input logic [7:0] di);
    bus.model = m; bus.cpu_a = a; bus.cpu_we = we; bus.cpu_di = di; bus.cpu_req = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int lat;
    v = vecs[i];
    drive(v.model, v.a, v.we, v.di);
    step();
    bus.cpu_req = 1'b0;
    chk($sformatf("v%0d sel", i), 32'(sels()), 32'(v.sel));
    chk($sformatf("v%0d busy", i), 32'(bus.slow_busy), 32'(v.slow));
    lat = 1;
    while (!bus.cpu_ready && lat < LIM) begin
      step();
      lat++;
    end
    if (!bus.cpu_ready) chk($sformatf("v%0d ready timeout", i), 0, 1);
    else if (!v.slow)   chk($sformatf("v%0d latency", i), 32'(lat), 2);
    else chk($sformatf("v%0d slow latency %0d in range", i, lat),
             32'(lat >= DIV / 2 + 2 && lat <= DIV / 2 + DIV + 1), 1);
    chk($sformatf("v%0d sel held", i), 32'(sels()), 32'(v.sel));
    step();
    chk($sformatf("v%0d sel dropped", i), 32'(sels()), 0);
    chk($sformatf("v%0d rom_bank", i), 32'(bus.rom_bank), 32'(v.bank));
    chk($sformatf("v%0d acccon", i), 32'(bus.acccon_q), 32'(v.acc));
    chk($sformatf("v%0d shadow", i), 32'(bus.shadow), 32'(v.acc[2]));
  endtask

  initial begin
    int lat, n_ready;
    bit ram_seen;

    vecs[0]  = '{1'b0, 16'h1234, 1'b0, 8'h00, S_RAM,    1'b0, 4'd0,  8'h00};
    vecs[1]  = '{1'b0, 16'hFE30, 1'b1, 8'h05, 21'h0008, 1'b0, 4'd5,  8'h00};
    vecs[2]  = '{1'b0, 16'h8000, 1'b0, 8'h00, S_ROM,    1'b0, 4'd5,  8'h00};
    vecs[3]  = '{1'b0, 16'hFE30, 1'b1, 8'h0C, 21'h0008, 1'b0, 4'd12, 8'h00};
    vecs[4]  = '{1'b0, 16'h8000, 1'b0, 8'h00, S_DDR,    1'b0, 4'd12, 8'h00};
    vecs[5]  = '{1'b0, 16'hC000, 1'b0, 8'h00, S_MOS,    1'b0, 4'd12, 8'h00};
    vecs[6]  = '{1'b0, 16'hFC10, 1'b0, 8'h00, S_FJ,     1'b1, 4'd12, 8'h00};
    vecs[7]  = '{1'b0, 16'hFEC5, 1'b0, 8'h00, 21'h1000, 1'b1, 4'd12, 8'h00};
    vecs[8]  = '{1'b1, 16'hFEC5, 1'b0, 8'h00, 21'h1000, 1'b0, 4'd12, 8'h00};
    vecs[9]  = '{1'b1, 16'hFE34, 1'b1, 8'h04, 21'h0008, 1'b0, 4'd12, 8'h04};
    vecs[10] = '{1'b1, 16'hFE38, 1'b1, 8'h07, 21'h0008, 1'b0, 4'd12, 8'h04};
    vecs[11] = '{1'b0, 16'hFE34, 1'b1, 8'h03, 21'h0008, 1'b0, 4'd3,  8'h00};
    vecs[12] = '{1'b0, 16'hFEFF, 1'b0, 8'h00, 21'h8000, 1'b0, 4'd3,  8'h00};
    vecs[13] = '{1'b0, 16'h7FFF, 1'b0, 8'h00, S_RAM,    1'b0, 4'd3,  8'h00};
    vecs[14] = '{1'b1, 16'hBFFF, 1'b0, 8'h00, S_ROM,    1'b0, 4'd3,  8'h04};
    vecs[15] = '{1'b0, 16'hFE18, 1'b0, 8'h00, 21'h0002, 1'b1, 4'd3,  8'h00};

    bus.model = 1'b0; bus.cpu_req = 1'b0; bus.cpu_a = '0; bus.cpu_we = 1'b0; bus.cpu_di = '0;
    repeat (2) step();
    chk("reset sel", 32'(sels()), 0);
    chk("reset ready", 32'(bus.cpu_ready), 0);
    chk("reset busy", 32'(bus.slow_busy), 0);
    chk("reset rom_bank", 32'(bus.rom_bank), 0);
    chk("reset acccon", 32'(bus.acccon_q), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) run_vec(i);

    // Slow access issued at phase DIV-2: the edge one cycle later is too early.
    lat = 0;
    while ((tb_cyc % DIV) != DIV - 2 && lat < LIM) begin
      step();
      lat++;
    end
    drive(1'b0, 16'hFE40, 1'b0, 8'h00);
    step();
    bus.cpu_req = 1'b0;
    chk("phase busy", 32'(bus.slow_busy), 1);
    lat = 1;
    while (!bus.cpu_ready && lat < LIM) begin
      step();
      lat++;
    end
    chk("phase latency", 32'(lat), 32'(DIV + 2));
    chk("phase io_cs", 32'(bus.io_cs), 32'h0010);
    chk("phase busy at ready", 32'(bus.slow_busy), 0);
    step();

    // Reset in the middle of a stretched access.
    do_reset();
    run_vec(1);
    drive(1'b0, 16'hFE40, 1'b1, 8'h09);
    step();
    bus.cpu_req = 1'b0;
    repeat (3) step();
    chk("rst busy before", 32'(bus.slow_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst async sel", 32'(sels()), 0);
    chk("rst async busy", 32'(bus.slow_busy), 0);
    chk("rst async bank", 32'(bus.rom_bank), 0);
    step();
    rst_n = 1'b1;
    n_ready = 0;
    for (int c = 0; c < 2 * DIV; c++) begin
      step();
      if (bus.cpu_ready) n_ready++;
    end
    chk("rst no ready", 32'(n_ready), 0);
    chk("rst sel idle", 32'(sels()), 0);
    chk("rst bank", 32'(bus.rom_bank), 0);

    // Requests during SLOW and in the ready cycle are both dropped.
    drive(1'b0, 16'hFE40, 1'b0, 8'h00);
    step();
    bus.cpu_req = 1'b0;
    repeat (3) step();
    drive(1'b0, 16'h1234, 1'b0, 8'h00);
    step();
    bus.cpu_req = 1'b0;
    n_ready = 0;
    ram_seen = 1'b0;
    for (int c = 0; c < LIM; c++) begin
      if (bus.ram_cs) ram_seen = 1'b1;
      if (bus.cpu_ready) begin
        n_ready++;
        if (n_ready == 1) drive(1'b0, 16'h1234, 1'b0, 8'h00);
      end
      step();
      bus.cpu_req = 1'b0;
    end
    chk("overlap ready count", 32'(n_ready), 1);
    chk("overlap ram never", 32'(ram_seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
